// File: rtl/or1200_ifetch_pair_pkg.sv
// rtl/or1200_ifetch_pair_pkg.sv - shared tag codes and constants for the paired instruction fetcher
//
// Purpose: instruction-tag codes and the NOP encoding used by the paired
// fetch unit, plus the word-alignment helper.
// Ports: none (package).
package or1200_ifetch_pair_pkg;

  // Instruction tags returned with a CPU response.
  localparam logic [3:0]  OR1200_ITAG_NI  = 4'h1;  // normal instruction
  localparam logic [3:0]  OR1200_ITAG_BE  = 4'hB;  // bus error

  // l.nop encoding, used to fill a slot that cannot be fetched.
  localparam logic [31:0] OR1200_OR32_NOP = 32'h1500_0000;

  // Last word of the address space; its successor would wrap to zero.
  localparam logic [31:0] LAST_WORD_ADR   = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/or1200_ifetch_pair.sv
// rtl/or1200_ifetch_pair.sv - two-word instruction fetcher with a one-entry bundle buffer
//
// Purpose: turns one CPU fetch at word address A into two 32-bit memory
// beats (A, A+4) and returns the pair as a 64-bit bundle {insn@A, insn@A+4}.
// The last returned bundle is buffered so a repeated request is answered
// without a memory cycle.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   icpu_adr_i/cycstb_i         CPU fetch address and request
//   icpu_sel_i/tag_i            CPU byte selects and tag (ignored)
//   icpu_dat_o/ack_o            bundle and bundle-valid strobe
//   icpu_rty_o/err_o            retry (tied 0) and bus-error strobe
//   icpu_adr_o/tag_o            address and tag of the response
//   imem_adr_o/cyc_o/stb_o      memory request
//   imem_dat_i/ack_i/err_i      memory response
module or1200_ifetch_pair
  import or1200_ifetch_pair_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = OR1200_OR32_NOP,
  parameter int          DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   icpu_adr_i,
  input  logic          icpu_cycstb_i,
  input  logic [3:0]    icpu_sel_i,
  input  logic [3:0]    icpu_tag_i,
  output logic [63:0]   icpu_dat_o,
  output logic          icpu_ack_o,
  output logic          icpu_rty_o,
  output logic          icpu_err_o,
  output logic [31:0]   icpu_adr_o,
  output logic [3:0]    icpu_tag_o,
  output logic [31:0]   imem_adr_o,
  output logic          imem_cyc_o,
  output logic          imem_stb_o,
  input  logic [DW-1:0] imem_dat_i,
  input  logic          imem_ack_i,
  input  logic          imem_err_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;              // latched word address of the request
  logic [31:0] hi_q, hi_d;            // insn@A
  logic [31:0] lo_q, lo_d;            // insn@A+4
  logic        abort_q, abort_d;      // request withdrawn while a beat is outstanding
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_adr_q, buf_adr_d;
  logic [63:0] buf_dat_q, buf_dat_d;
  logic        err_q, err_d;
  logic [31:0] radr_q, radr_d;        // address reported with ack/err
  logic [3:0]  rtag_q, rtag_d;

  logic [31:0] req_adr;
  logic        buf_hit;
  logic        beat_abort;
  logic        in_beat;
  logic        unused_inputs;

  assign unused_inputs = ^{icpu_sel_i, icpu_tag_i, icpu_adr_i[1:0]};

  assign req_adr = word_align(icpu_adr_i);
  assign buf_hit = buf_valid_q && (buf_adr_q == req_adr);

  // Once withdrawn, a request stays aborted even if the CPU re-presents it
  // before the outstanding beat finishes.
  assign beat_abort = abort_q || !icpu_cycstb_i || (req_adr != a_q);

  assign in_beat = (state_q == S_BEAT0) || (state_q == S_BEAT1);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    abort_d     = abort_q;
    buf_valid_d = buf_valid_q;
    buf_adr_d   = buf_adr_q;
    buf_dat_d   = buf_dat_q;
    err_d       = 1'b0;
    radr_d      = radr_q;
    rtag_d      = rtag_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (icpu_cycstb_i) begin
          a_d = req_adr;
          if (buf_hit) begin
            hi_d    = buf_dat_q[63:32];
            lo_d    = buf_dat_q[31:0];
            radr_d  = req_adr;
            rtag_d  = OR1200_ITAG_NI;
            state_d = S_RESP;
          end else begin
            state_d = S_BEAT0;
          end
        end
      end

      S_BEAT0: begin
        abort_d = beat_abort;
        if (imem_ack_i) begin
          if (beat_abort) begin
            buf_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            hi_d = imem_dat_i;
            if (a_q == LAST_WORD_ADR) begin
              // No wrap-around fetch: the second slot becomes a NOP.
              lo_d    = NOP_INSN;
              radr_d  = a_q;
              rtag_d  = OR1200_ITAG_NI;
              state_d = S_RESP;
            end else begin
              state_d = S_BEAT1;
            end
          end
        end else if (imem_err_i) begin
          buf_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (!beat_abort) begin
            err_d  = 1'b1;
            radr_d = a_q;
            rtag_d = OR1200_ITAG_BE;
          end
        end
      end

      S_BEAT1: begin
        abort_d = beat_abort;
        if (imem_ack_i) begin
          if (beat_abort) begin
            buf_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            lo_d    = imem_dat_i;
            radr_d  = a_q;
            rtag_d  = OR1200_ITAG_NI;
            state_d = S_RESP;
          end
        end else if (imem_err_i) begin
          buf_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (!beat_abort) begin
            err_d  = 1'b1;
            radr_d = a_q + 32'd4;
            rtag_d = OR1200_ITAG_BE;
          end
        end
      end

      S_RESP: begin
        buf_valid_d = 1'b1;
        buf_adr_d   = a_q;
        buf_dat_d   = {hi_q, lo_q};
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      hi_q        <= NOP_INSN;
      lo_q        <= NOP_INSN;
      abort_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_adr_q   <= 32'd0;
      buf_dat_q   <= 64'd0;
      err_q       <= 1'b0;
      radr_q      <= 32'd0;
      rtag_q      <= OR1200_ITAG_NI;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      abort_q     <= abort_d;
      buf_valid_q <= buf_valid_d;
      buf_adr_q   <= buf_adr_d;
      buf_dat_q   <= buf_dat_d;
      err_q       <= err_d;
      radr_q      <= radr_d;
      rtag_q      <= rtag_d;
    end
  end

  // Outputs are forced to their idle values while rst is high so a reset
  // landing mid-beat drops the bus request in the same cycle.
  assign imem_cyc_o = in_beat && !rst;
  assign imem_stb_o = in_beat && !rst;
  assign imem_adr_o = (state_q == S_BEAT1) ? (a_q + 32'd4) : a_q;

  assign icpu_ack_o = (state_q == S_RESP) && !rst;
  assign icpu_err_o = err_q && !rst;
  assign icpu_rty_o = 1'b0;
  assign icpu_dat_o = rst ? {NOP_INSN, NOP_INSN} : {hi_q, lo_q};
  assign icpu_adr_o = rst ? 32'd0 : radr_q;
  assign icpu_tag_o = rst ? OR1200_ITAG_NI : rtag_q;

endmodule
